xor_parity_scheduler: RTL and testbench
=======================================

# xor_parity_scheduler

Round-robin scheduler that shares one XOR-reduction datapath (word-wide XOR accumulator followed by a register) between NREQ requesters. A granted requester streams a burst of LEN words onto the shared data bus. The block folds the words into the accumulator and returns the XOR of the burst plus its reduction parity, tagged with the requester ID. It sits between the requesting channels and the XOR/DFF parity datapath and is the only block that sequences that datapath.

## Interface
- NREQ, 4: number of requesters (2..8).
- DW, 8: data word width.
- LEN_W, 4: burst-length field width; bursts of 0..2^LEN_W-1 words.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  level request per requester; held high for the whole burst.
- len  in  NREQ*LEN_W  packed burst lengths; requester i uses bits [i*LEN_W +: LEN_W]. Sampled only at grant.
- grant  out  NREQ  registered one-hot grant, all zeros when idle.
- data_in  in  DW  shared data bus, driven by the granted requester.
- data_valid  in  1  data_in holds a valid word.
- data_ready  out  1  high in ACCUM; a word transfers when valid && ready.
- res_valid  out  1  one-cycle result strobe.
- res_data  out  DW  XOR of all burst words.
- res_parity  out  1  reduction XOR of res_data.
- res_id  out  $clog2(NREQ)  index of the requester the result belongs to.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, ACCUM, DONE.
- **IDLE**
  - If any req bit is high, the round-robin winner is chosen. The search starts at pointer ptr and wraps through NREQ-1 back to 0.
  - Next cycle: grant = onehot(winner), cnt = len[winner], acc = 0, id = winner.
  - If len[winner] == 0, go to DONE. Otherwise go to ACCUM.
  - With no req, stay in IDLE.
- **ACCUM**
  - data_ready = 1.
  - On each transfer: acc <= acc ^ data_in and cnt <= cnt - 1.
  - A transfer with cnt == 1 goes to DONE.
  - If valid is low, hold state; no timeout.
- **Abort:** if req[id] falls in ACCUM, go to IDLE the next cycle. grant clears, no res_valid is produced, and ptr advances to id+1. A transfer in the same cycle as the abort is discarded.
- **DONE**
  - res_valid = 1 for exactly one cycle, with res_data = acc, res_parity = ^acc, res_id = id.
  - grant clears. ptr <= (id+1) mod NREQ. Go to IDLE.
- res_data, res_parity and res_id hold their last values between strobes.
- A requester that keeps req high after DONE is served again only after higher-rotation requesters are served.
- req bits of non-granted requesters are ignored outside IDLE.
- len changes after grant have no effect.

## Timing
- Reset (async assert, synchronous deassert by the environment): state IDLE, ptr 0 (requester 0 has first priority), and every output is 0.
  - This covers grant, data_ready, res_valid, res_data, res_parity, res_id and busy.
- Reset asserted mid-burst discards the burst immediately; no result is emitted.
- Latency:
  - req high in IDLE at edge k: grant high after edge k+1.
  - First data_ready after edge k+1.
  - With len = L and valid continuously high, res_valid is high after edge k+L+1, i.e. the cycle after the last transfer.
  - Minimum request-to-next-grant turnaround is 1 idle cycle; throughput is L+2 cycles per burst.
- len = 0: grant for one cycle (ACCUM skipped), then DONE with res_data = 0, res_parity = 0.
- len = 2^LEN_W-1: cnt must not wrap; exactly that many transfers are accepted.
- Simultaneous requests are resolved purely by the ptr rotation; no fixed priority after reset.

## Structure
- Package xor_sched_pkg:
  - state enum (IDLE, ACCUM, DONE);
  - default NREQ/DW/LEN_W constants;
  - ID_W = $clog2(NREQ) helper.
- Sub-module xor_rr_arbiter: combinational round-robin pick. Inputs req and ptr; outputs winner index and any_req.
- Accumulator, counter and FSM stay in xor_parity_scheduler.

## Test plan
- Reset then req=4'b0001, len0=3, words 0x0F, 0xF0, 0x3C → grant=0001 after 1 cycle; res_valid once with res_data=0xC3, res_parity=0, res_id=0.
- req=4'b1111 held, all len=1, data 0x01 → grants in order 0,1,2,3,0; each res_data=0x01, res_parity=1.
- req=4'b0010, len1=0 → grant 0010 for one cycle, res_valid next cycle with res_data=0x00, res_id=1, no data_ready.
- req=4'b0100, len2=4, valid toggled 1,0,1,0,1,1 with words 0xAA, 0x55, 0xFF, 0x01 → exactly 4 transfers; res_data=0x01.
- len3=5, req3 dropped after 2 transfers → no res_valid; grant clears the next cycle; a subsequent req=4'b1001 grants requester 0 (ptr=0).
- rst pulsed during ACCUM → all outputs 0 immediately (asynchronously); after release, req=4'b1000 is served with correct result.

Source files
------------

// File: rtl/xor_sched_pkg.sv
// xor_sched_pkg: shared state type and default sizing for the XOR parity scheduler
package xor_sched_pkg;
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
   localparam int NREQ_DEF = 4;
   localparam int DW_DEF = 8;
   localparam int LEN_W_DEF = 4;
   function automatic int id_w(input int n);
      return $clog2(n);
   endfunction
   localparam int ID_W_DEF = id_w(NREQ_DEF);
endpackage

// File: rtl/xor_rr_arbiter.sv
// xor_rr_arbiter: combinational round-robin pick starting at ptr and wrapping
module xor_rr_arbiter
   import xor_sched_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   localparam int ID_W = id_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] ptr,
   output logic [ID_W-1:0] winner,
   output logic            any_req
);
   logic [ID_W-1:0] idx;
   // scan farthest-first so the requester closest to ptr overwrites last
   always_comb begin
      winner = '0;
      idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = ID_W'((int'(ptr) + i) % NREQ);
         if (req[idx]) winner = idx;
      end
   end
   assign any_req = |req;
endmodule

// File: rtl/xor_parity_scheduler.sv
// xor_parity_scheduler: round-robin sharing of one XOR accumulator, returns burst XOR and parity
module xor_parity_scheduler
   import xor_sched_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int DW = DW_DEF,
   parameter int LEN_W = LEN_W_DEF,
   localparam int ID_W = id_w(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*LEN_W-1:0] len,
   output logic [NREQ-1:0]       grant,
   input  logic [DW-1:0]         data_in,
   input  logic                  data_valid,
   output logic                  data_ready,
   output logic                  res_valid,
   output logic [DW-1:0]         res_data,
   output logic                  res_parity,
   output logic [ID_W-1:0]       res_id,
   output logic                  busy
);
   state_t state_q;
   logic [ID_W-1:0] ptr_q, id_q, res_id_q, winner, next_id;
   logic [LEN_W-1:0] cnt_q, win_len;
   logic [DW-1:0] acc_q, acc_d, res_data_q;
   logic [NREQ-1:0] grant_q;
   logic res_valid_q, res_parity_q, any_req;
   logic [LEN_W-1:0] len_a [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_len
      assign len_a[g] = len[g*LEN_W +: LEN_W];
   end

   xor_rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req    (req),
      .ptr    (ptr_q),
      .winner (winner),
      .any_req(any_req)
   );

   assign win_len = len_a[winner];
   assign acc_d = acc_q ^ data_in;
   assign next_id = (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + 1'b1;

   // results are loaded on entry to DONE so res_valid lines up with the DONE cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q <= '0;
         id_q <= '0;
         cnt_q <= '0;
         acc_q <= '0;
         grant_q <= '0;
         res_valid_q <= 1'b0;
         res_data_q <= '0;
         res_parity_q <= 1'b0;
         res_id_q <= '0;
      end else begin
         res_valid_q <= 1'b0;
         case (state_q)
            IDLE: if (any_req) begin
               grant_q <= NREQ'(1) << winner;
               cnt_q <= win_len;
               acc_q <= '0;
               id_q <= winner;
               if (win_len == '0) begin
                  state_q <= DONE;
                  res_valid_q <= 1'b1;
                  res_data_q <= '0;
                  res_parity_q <= 1'b0;
                  res_id_q <= winner;
               end else begin
                  state_q <= ACCUM;
               end
            end
            ACCUM: if (!req[id_q]) begin
               state_q <= IDLE;
               grant_q <= '0;
               ptr_q <= next_id;
            end else if (data_valid) begin
               acc_q <= acc_d;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == LEN_W'(1)) begin
                  state_q <= DONE;
                  res_valid_q <= 1'b1;
                  res_data_q <= acc_d;
                  res_parity_q <= ^acc_d;
                  res_id_q <= id_q;
               end
            end
            DONE: begin
               grant_q <= '0;
               ptr_q <= next_id;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign grant = grant_q;
   assign data_ready = (state_q == ACCUM);
   assign busy = (state_q != IDLE);
   assign res_valid = res_valid_q;
   assign res_data = res_data_q;
   assign res_parity = res_parity_q;
   assign res_id = res_id_q;
endmodule

// File: tb/tb_xor_parity_scheduler.sv
// tb_xor_parity_scheduler: vector table, corner sequences and randomized bursts vs a transaction model
module tb_xor_parity_scheduler;
   logic clk = 1'b0;
   logic rst;
   logic [3:0] req, grant;
   logic [15:0] len;
   logic [7:0] data_in, res_data;
   logic data_valid, data_ready, res_valid, res_parity, busy;
   logic [1:0] res_id;
   int total = 0;
   int bad = 0;

   typedef struct {
      int id;
      int l;
      logic [3:0][7:0] w;
      bit gaps;
      logic [7:0] ed;
      logic ep;
   } vec_t;
   vec_t tbl [7];

   xor_parity_scheduler dut (
      .clk(clk), .rst(rst), .req(req), .len(len), .grant(grant),
      .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
      .res_valid(res_valid), .res_data(res_data), .res_parity(res_parity),
      .res_id(res_id), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, " grant"}, 32'(grant), 0);
      check({tag, " data_ready"}, 32'(data_ready), 0);
      check({tag, " res_valid"}, 32'(res_valid), 0);
      check({tag, " res_data"}, 32'(res_data), 0);
      check({tag, " res_parity"}, 32'(res_parity), 0);
      check({tag, " res_id"}, 32'(res_id), 0);
      check({tag, " busy"}, 32'(busy), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      data_valid = 1'b0;
      #1;
      check_zero_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
   endtask

   // one burst from IDLE: request, stream words, then check result or abort behaviour
   task automatic burst(input logic [3:0] mask, input logic [15:0] lens, input int id,
                        input logic [15:0][7:0] w, input bit gaps, input int abort_at,
                        input logic [7:0] ed, input logic ep);
      int l, n, cyc;
      logic v;
      l = int'(lens[id*4 +: 4]);
      req = mask;
      len = lens;
      data_valid = 1'b0;
      data_in = 8'($urandom);
      tick();
      check("grant", 32'(grant), 32'(1) << id);
      check("busy", 32'(busy), 1);
      n = 0;
      cyc = 0;
      while (n < l && n != abort_at && cyc < 100) begin
         check("data_ready", 32'(data_ready), 1);
         check("no early res_valid", 32'(res_valid), 0);
         v = gaps ? (cyc % 2 == 0) : 1'b1;
         data_valid = v;
         data_in = v ? w[n] : 8'($urandom);
         tick();
         if (v) n++;
         cyc++;
      end
      if (cyc >= 100) check("transfer budget", 32'(cyc), 0);
      if (abort_at >= 0 && abort_at < l) begin
         req = '0;
         data_valid = 1'b1;
         data_in = 8'($urandom);
         tick();
         check("abort grant", 32'(grant), 0);
         check("abort res_valid", 32'(res_valid), 0);
         check("abort busy", 32'(busy), 0);
         data_valid = 1'b0;
         return;
      end
      data_valid = 1'b0;
      check("res_valid", 32'(res_valid), 1);
      check("res_data", 32'(res_data), 32'(ed));
      check("res_parity", 32'(res_parity), 32'(ep));
      check("res_id", 32'(res_id), 32'(id));
      check("grant in done", 32'(grant), 32'(1) << id);
      check("ready in done", 32'(data_ready), 0);
      req = '0;
      tick();
      check("strobe one cycle", 32'(res_valid), 0);
      check("grant cleared", 32'(grant), 0);
      check("res_data hold", 32'(res_data), 32'(ed));
      check("res_id hold", 32'(res_id), 32'(id));
   endtask

   initial begin
      logic [15:0][7:0] w16;
      logic [15:0] lens;
      logic [7:0] ed;
      logic ep;
      int cyc, mptr, win, l, ab;
      logic [3:0] mask;
      rst = 1'b1;
      req = '0;
      len = '0;
      data_in = '0;
      data_valid = 1'b0;
      tbl[0] = '{0, 3, {8'h00, 8'h3C, 8'hF0, 8'h0F}, 1'b0, 8'hC3, 1'b0};
      tbl[1] = '{1, 0, {8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 8'h00, 1'b0};
      tbl[2] = '{2, 4, {8'h01, 8'hFF, 8'h55, 8'hAA}, 1'b1, 8'h01, 1'b1};
      tbl[3] = '{3, 2, {8'h00, 8'h00, 8'h34, 8'h12}, 1'b0, 8'h26, 1'b1};
      tbl[4] = '{0, 1, {8'h00, 8'h00, 8'h00, 8'h80}, 1'b0, 8'h80, 1'b1};
      tbl[5] = '{1, 4, {8'h08, 8'h04, 8'h02, 8'h01}, 1'b0, 8'h0F, 1'b0};
      tbl[6] = '{3, 3, {8'h00, 8'hFF, 8'hFF, 8'hFF}, 1'b1, 8'hFF, 1'b0};
      do_reset();

      for (int i = 0; i < 7; i++) begin
         w16 = '0;
         w16[3:0] = tbl[i].w;
         lens = 16'($urandom);
         lens[tbl[i].id*4 +: 4] = 4'(tbl[i].l);
         burst(4'(1) << tbl[i].id, lens, tbl[i].id, w16, tbl[i].gaps, -1, tbl[i].ed, tbl[i].ep);
      end

      for (int k = 0; k < 16; k++) w16[k] = 8'(k + 1);
      burst(4'b0100, 16'h0F00, 2, w16, 1'b0, -1, 8'h00, 1'b0);

      do_reset();
      req = 4'hF;
      len = 16'h1111;
      data_valid = 1'b1;
      data_in = 8'h01;
      for (int i = 0; i < 5; i++) begin
         cyc = 0;
         tick();
         while (grant == 0 && cyc < 10) begin
            tick();
            cyc++;
         end
         check("rr grant", 32'(grant), 32'(1) << (i % 4));
         check("rr turnaround", 32'(cyc), (i > 0) ? 1 : 0);
         tick();
         check("rr res_valid", 32'(res_valid), 1);
         check("rr res_id", 32'(res_id), 32'(i % 4));
         check("rr res_data", 32'(res_data), 32'h01);
         check("rr res_parity", 32'(res_parity), 1);
      end
      req = '0;
      data_valid = 1'b0;
      tick();

      do_reset();
      for (int k = 0; k < 16; k++) w16[k] = 8'($urandom);
      burst(4'b1000, 16'h5000, 3, w16, 1'b0, 2, 8'h00, 1'b0);
      req = 4'b1001;
      len = 16'h5001;
      data_valid = 1'b1;
      data_in = 8'h5A;
      tick();
      check("post-abort grant", 32'(grant), 32'h1);
      tick();
      check("post-abort res_valid", 32'(res_valid), 1);
      check("post-abort res_id", 32'(res_id), 0);
      check("post-abort res_data", 32'(res_data), 32'h5A);
      req = '0;
      data_valid = 1'b0;
      tick();

      req = 4'b1000;
      len = 16'h5000;
      tick();
      data_valid = 1'b1;
      data_in = 8'h11;
      tick();
      tick();
      rst = 1'b1;
      #1;
      check_zero_outputs("mid-burst reset");
      @(negedge clk);
      rst = 1'b0;
      req = '0;
      data_valid = 1'b0;
      w16 = '0;
      w16[0] = 8'hAB;
      w16[1] = 8'hCD;
      w16[2] = 8'hEF;
      burst(4'b1000, 16'h3000, 3, w16, 1'b0, -1, 8'h89, 1'b1);

      do_reset();
      mptr = 0;
      for (int it = 0; it < 40; it++) begin
         mask = 4'($urandom_range(1, 15));
         win = -1;
         for (int off = 0; off < 4; off++)
            if (win < 0 && mask[(mptr + off) % 4]) win = (mptr + off) % 4;
         lens = 16'($urandom);
         l = int'(lens[win*4 +: 4]);
         for (int k = 0; k < 16; k++) w16[k] = 8'($urandom);
         ed = '0;
         for (int k = 0; k < l; k++) ed = ed ^ w16[k];
         ep = 1'($countones(ed) % 2);
         ab = (l > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, l - 1)) : -1;
         burst(mask, lens, win, w16, 1'($urandom), ab, ed, ep);
         mptr = (win + 1) % 4;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
